// File: rtl/segre_pkg.sv
// segre_pkg: shared widths and types for the SEGRE memory subsystem.
//   ADDR_SIZE         line address width
//   DCACHE_LANE_SIZE  D-cache line (and main-memory bus) width
//   ICACHE_LANE_SIZE  I-cache line width
//   arb_fsm_state_e   state encoding of segre_mem_arbiter
package segre_pkg;

    localparam int ADDR_SIZE        = 32;
    localparam int DCACHE_LANE_SIZE = 128;
    localparam int ICACHE_LANE_SIZE = 128;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_DC_WB   = 2'd1,
        ARB_DC_FILL = 2'd2,
        ARB_IC_FILL = 2'd3
    } arb_fsm_state_e;

endpackage

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares one main-memory port between the D-cache and the
// I-cache. One memory transaction is outstanding at a time; the D-cache has
// priority, and a dirty D-cache miss writes its victim back before the fill.
// All mm_* outputs come straight from registers.
//
// Optional feature (macro SEGRE_ARB_AGING_EN): an I-cache miss that has been
// waiting AGE_LIMIT cycles wins the idle arbitration over the D-cache.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   dc_miss_i, dc_addr_i               D-cache fill request / line address
//   dc_writeback_i, dc_wb_addr_i,
//   dc_wb_data_i                       dirty victim to write back first
//   dc_data_o, dc_data_rdy_o           D-cache fill data / one-cycle done pulse
//   ic_miss_i, ic_addr_i, ic_kill_i    I-cache fill request / address / cancel
//   ic_data_o, ic_data_rdy_o           I-cache fill data / one-cycle done pulse
//   mm_rd_o, mm_wr_o, mm_addr_o,
//   mm_data_o, mm_data_i, mm_ack_i     main-memory request/response
//
// state       | meaning
// ARB_IDLE    | no transaction; arbitrate pending misses
// ARB_DC_WB   | writing the dirty D-cache victim to memory
// ARB_DC_FILL | reading the D-cache line from memory
// ARB_IC_FILL | reading the I-cache line from memory (may be killed)
import segre_pkg::*;

module segre_mem_arbiter #(
    parameter int AGE_LIMIT = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        dc_miss_i,
    input  logic [ADDR_SIZE-1:0]        dc_addr_i,
    input  logic                        dc_writeback_i,
    input  logic [ADDR_SIZE-1:0]        dc_wb_addr_i,
    input  logic [DCACHE_LANE_SIZE-1:0] dc_wb_data_i,
    output logic [DCACHE_LANE_SIZE-1:0] dc_data_o,
    output logic                        dc_data_rdy_o,
    input  logic                        ic_miss_i,
    input  logic [ADDR_SIZE-1:0]        ic_addr_i,
    input  logic                        ic_kill_i,
    output logic [ICACHE_LANE_SIZE-1:0] ic_data_o,
    output logic                        ic_data_rdy_o,
    output logic                        mm_rd_o,
    output logic                        mm_wr_o,
    output logic [ADDR_SIZE-1:0]        mm_addr_o,
    output logic [DCACHE_LANE_SIZE-1:0] mm_data_o,
    input  logic [DCACHE_LANE_SIZE-1:0] mm_data_i,
    input  logic                        mm_ack_i
);

    if (AGE_LIMIT < 1) begin : g_age_limit_check
        $error("segre_mem_arbiter: AGE_LIMIT must be at least 1");
    end

    arb_fsm_state_e              state_q, state_d;
    logic                        kill_q, kill_d;
    logic [ADDR_SIZE-1:0]        fill_addr_q, fill_addr_d;
    logic                        mm_rd_d, mm_wr_d;
    logic [ADDR_SIZE-1:0]        mm_addr_d;
    logic [DCACHE_LANE_SIZE-1:0] mm_data_d;
    logic [DCACHE_LANE_SIZE-1:0] dc_data_d;
    logic [ICACHE_LANE_SIZE-1:0] ic_data_d;
    logic                        dc_rdy_d, ic_rdy_d;
    logic                        dc_eligible, ic_eligible;
    logic                        ic_aged;

`ifdef SEGRE_ARB_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q, age_d;

    assign ic_aged = (age_q == AGE_W'(AGE_LIMIT));

    always_comb begin
        age_d = age_q;
        if (ic_kill_i || (state_q == ARB_IDLE && state_d == ARB_IC_FILL)) begin
            age_d = '0;
        end else if (ic_miss_i && state_q != ARB_IC_FILL && !ic_aged) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) age_q <= '0;
        else       age_q <= age_d;
    end
`else
    assign ic_aged = 1'b0;
`endif

    // A miss whose rdy pulse is on the wire this cycle is the one just served.
    assign dc_eligible = dc_miss_i && !dc_data_rdy_o;
    assign ic_eligible = ic_miss_i && !ic_kill_i && !ic_data_rdy_o;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        fill_addr_d = fill_addr_q;
        mm_rd_d     = mm_rd_o;
        mm_wr_d     = mm_wr_o;
        mm_addr_d   = mm_addr_o;
        mm_data_d   = mm_data_o;
        dc_data_d   = dc_data_o;
        ic_data_d   = ic_data_o;
        dc_rdy_d    = 1'b0;
        ic_rdy_d    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                kill_d = 1'b0;
                if (ic_eligible && ic_aged) begin
                    state_d   = ARB_IC_FILL;
                    mm_rd_d   = 1'b1;
                    mm_addr_d = ic_addr_i;
                end else if (dc_eligible) begin
                    fill_addr_d = dc_addr_i;
                    if (dc_writeback_i) begin
                        state_d   = ARB_DC_WB;
                        mm_wr_d   = 1'b1;
                        mm_addr_d = dc_wb_addr_i;
                        mm_data_d = dc_wb_data_i;
                    end else begin
                        state_d   = ARB_DC_FILL;
                        mm_rd_d   = 1'b1;
                        mm_addr_d = dc_addr_i;
                    end
                end else if (ic_eligible) begin
                    state_d   = ARB_IC_FILL;
                    mm_rd_d   = 1'b1;
                    mm_addr_d = ic_addr_i;
                end
            end
            ARB_DC_WB: begin
                if (mm_ack_i) begin
                    state_d   = ARB_DC_FILL;
                    mm_wr_d   = 1'b0;
                    mm_rd_d   = 1'b1;
                    mm_addr_d = fill_addr_q;
                end
            end
            ARB_DC_FILL: begin
                if (mm_ack_i) begin
                    state_d   = ARB_IDLE;
                    mm_rd_d   = 1'b0;
                    dc_data_d = mm_data_i;
                    dc_rdy_d  = 1'b1;
                end
            end
            ARB_IC_FILL: begin
                if (ic_kill_i) kill_d = 1'b1;
                if (mm_ack_i) begin
                    state_d = ARB_IDLE;
                    mm_rd_d = 1'b0;
                    kill_d  = 1'b0;
                    // A kill in the ack cycle itself also discards the line.
                    if (!kill_q && !ic_kill_i) begin
                        ic_data_d = mm_data_i[ICACHE_LANE_SIZE-1:0];
                        ic_rdy_d  = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ARB_IDLE;
            kill_q        <= 1'b0;
            fill_addr_q   <= '0;
            mm_rd_o       <= 1'b0;
            mm_wr_o       <= 1'b0;
            mm_addr_o     <= '0;
            mm_data_o     <= '0;
            dc_data_o     <= '0;
            ic_data_o     <= '0;
            dc_data_rdy_o <= 1'b0;
            ic_data_rdy_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            fill_addr_q   <= fill_addr_d;
            mm_rd_o       <= mm_rd_d;
            mm_wr_o       <= mm_wr_d;
            mm_addr_o     <= mm_addr_d;
            mm_data_o     <= mm_data_d;
            dc_data_o     <= dc_data_d;
            ic_data_o     <= ic_data_d;
            dc_data_rdy_o <= dc_rdy_d;
            ic_data_rdy_o <= ic_rdy_d;
        end
    end

endmodule
